// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access-size encodings,
// controller state enumeration, read-latency bounds and the alignment rule.
package mem_access_unit_pkg;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int CNT_W       = 3;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_FINISH
    } state_e;

    // Reserved size, odd halfword address or non-word-aligned word address.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b1;
        if (size == SZ_WORD)      bad = (lo != 2'b00);
        else if (size == SZ_BYTE) bad = 1'b0;
        else if (size == SZ_HALF) bad = lo[0];
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_mux.sv
// Little-endian lane insert/extract for byte and halfword accesses.
//   i_word    : word read from memory
//   i_wdata   : store data (low byte/half used)
//   i_size    : access size encoding
//   i_lane    : address bits [1:0]
//   o_insert  : i_word with the addressed lane replaced by store data
//   o_extract : addressed lane of i_word, sign-extended (word passes through)
module mem_lane_mux
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [15:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_insert,
    output logic [31:0] o_extract
);

    logic [4:0]  w_boff;
    logic [4:0]  w_hoff;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_boff = {i_lane, 3'b000};
    assign w_hoff = {i_lane[1], 4'b0000};
    assign w_byte = i_word[w_boff +: 8];
    assign w_half = i_word[w_hoff +: 16];

    always_comb begin
        o_insert  = i_word;
        o_extract = i_word;
        if (i_size == SZ_BYTE) begin
            o_insert[w_boff +: 8] = i_wdata[7:0];
            o_extract             = {{24{w_byte[7]}}, w_byte};
        end else if (i_size == SZ_HALF) begin
            o_insert[w_hoff +: 16] = i_wdata;
            o_extract              = {{16{w_half[15]}}, w_half};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store controller in front of a fixed-latency word memory.
// Sub-word stores are done as read-modify-write.
//   clk, rst        : clock, asynchronous active-high reset
//   i_req           : request (accepted only in IDLE)
//   i_we, i_size    : store/load, access size
//   i_addr, i_wdata : byte address, store data
//   o_busy, o_done  : not-idle flag, one-cycle completion pulse
//   o_err, o_rdata  : misalignment flag (with done), sign-extended load result
//   o_mem_*         : word-addressed memory port; i_mem_rdata valid MEM_LAT cycles
//                     after o_mem_addr changes
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [15:0]       r_wdata;
    logic [31:0]       r_rmw;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_mem_wr;
    logic              w_misalign;
    logic [31:0]       w_lane_word;
    logic [31:0]       w_insert;
    logic [31:0]       w_extract;

    assign w_misalign = f_misaligned(i_size, i_addr[1:0]);
    // MERGE works on the captured read word; loads extract straight from memory.
    assign w_lane_word = (r_state == S_MERGE) ? r_rmw : i_mem_rdata;

    mem_lane_mux u_lane (
        .i_word    (w_lane_word),
        .i_wdata   (r_wdata),
        .i_size    (r_size),
        .i_lane    (r_lane),
        .o_insert  (w_insert),
        .o_extract (w_extract)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_misalign)                      w_next = S_FINISH;
                    else if (i_we && i_size == SZ_WORD)  w_next = S_WRITE;
                    else                                 w_next = S_READ;
                end
            end
            S_READ:   if (r_cnt == '0) w_next = r_we ? S_MERGE : S_FINISH;
            S_MERGE:  w_next = S_WRITE;
            S_WRITE:  w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_rmw       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_wr    <= 1'b0;
        end else begin
            r_state  <= w_next;
            // Outputs are decoded from the next state so they line up with it.
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_FINISH);
            r_mem_wr <= (w_next == S_WRITE);
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_size  <= i_size;
                        r_lane  <= i_addr[1:0];
                        r_wdata <= i_wdata[15:0];
                        r_err   <= w_misalign;
                        r_cnt   <= CNT_LOAD;
                        if (!w_misalign) r_mem_addr <= {i_addr[31:2], 2'b00};
                        if (!w_misalign && i_we && i_size == SZ_WORD) r_mem_wdata <= i_wdata;
                    end
                end
                S_READ: begin
                    if (r_cnt == '0) begin
                        if (r_we) r_rmw   <= i_mem_rdata;
                        else      r_rdata <= w_extract;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_MERGE: r_mem_wdata <= w_insert;
                default: ;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rdata     = r_rdata;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, fixed memory read latency in cycles (legal 1..7).
REQ-002 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port req, input, 1, access request; sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-006 The block SHALL have port size, input, 2, access size: 0 = word, 1 = byte, 2 = halfword, 3 = reserved.
REQ-007 The block SHALL have port addr, input, 32, byte address.
REQ-008 The block SHALL have port wdata, input, 32, store data; byte/half taken from the low bits.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port err, output, 1, misalignment/reserved-size flag; valid while done is high.
REQ-012 The block SHALL have port rdata, output, 32, load result, sign-extended; held until the next load completes.
REQ-013 The block SHALL have ports mem_addr (output, 32, word address with bits [1:0] = 0), mem_wr (output, 1, write strobe), mem_wdata (output, 32, write word) and mem_rdata (input, 32, read word, valid MEM_LAT cycles after mem_addr is presented).

Function
REQ-014 On the clk edge where state = IDLE and req = 1, the block SHALL latch we, size, addr and wdata; req while busy SHALL be ignored.
REQ-015 The block SHALL implement states IDLE, READ, MERGE, WRITE and FINISH, with all outputs registered.
REQ-016 Error path: if size = 3, or size = 2 with addr[0] = 1, or size = 0 with addr[1:0] != 0, the block SHALL go IDLE -> FINISH with err = 1 and SHALL issue no memory access.
REQ-017 Load path: IDLE -> READ for MEM_LAT cycles -> FINISH; rdata SHALL be loaded from mem_rdata on the READ -> FINISH edge.
REQ-018 Word store: IDLE -> WRITE -> FINISH.
REQ-019 Byte/half store (read-modify-write): IDLE -> READ (MEM_LAT cycles) -> MERGE -> WRITE -> FINISH.
REQ-020 Done latency, counted from the accepting edge: error 1 cycle, load MEM_LAT+1, word store 2, sub-word store MEM_LAT+3 cycles.
REQ-021 Byte lanes SHALL be little-endian:
  - byte n at addr[1:0] = n maps to bits [8n+7:8n];
  - a halfword at addr[1] = h maps to bits [16h+15:16h].
REQ-022 The MERGE state SHALL replace only the addressed lane of the read word with wdata's low byte/half; all other lanes SHALL be preserved.
REQ-023 Loads SHALL sign-extend: byte from bit 7 of the lane, half from bit 15; a word load SHALL pass through unchanged.
REQ-024 mem_wr SHALL be 1 only in WRITE (exactly one cycle per store); mem_addr SHALL hold {addr[31:2],2'b00} from READ/WRITE entry through FINISH.
REQ-025 done SHALL be high only in FINISH; FINISH SHALL always return to IDLE; a req in the FINISH cycle SHALL be ignored.
REQ-026 err SHALL clear on the next accepted request; rdata SHALL NOT change on stores or errors.

Reset
REQ-027 When rst = 1, the block SHALL immediately force: state = IDLE; busy, done, err and mem_wr = 0; rdata, mem_addr and mem_wdata = 0; wait counter = 0.
REQ-028 A reset during READ, MERGE or WRITE SHALL abort the access with no further mem_wr pulse; the next request SHALL proceed normally.

Structure
REQ-029 A shared package SHALL hold the size encodings (WORD = 0, BYTE = 1, HALF = 2), the state enumeration and MEM_LAT bounds.
REQ-030 Lane insert/extract and sign extension SHALL be one combinational sub-module, mem_lane_mux.

Verification (MEM_LAT = 2)
REQ-031 Sub-word store: mem[0x10] = 0x11223344, store byte 0xAB at 0x11 -> single mem_wr with mem_addr 0x10, mem_wdata 0x1122AB44, done at cycle 5.
REQ-032 Byte load: mem[0x10] = 0x80FF0000, load byte at 0x13 -> rdata 0xFFFFFF80, done at cycle 3; load half at 0x12 -> rdata 0xFFFF80FF.
REQ-033 Word store: store 0xDEADBEEF at 0x20 -> mem_wr at cycle 1, done at cycle 2, no read issued.
REQ-034 Error cases: half load at 0x21 or word store at 0x22 -> done with err = 1 at cycle 1, no mem_wr, rdata unchanged.
REQ-035 Reset during READ of a byte store -> busy = 0 and mem_wr = 0 immediately, memory unchanged; a following word load completes normally.
REQ-036 Back-to-back: req held high continuously -> accepts only in IDLE, exactly one done per accepted request, busy = 1 between accept and FINISH.
